ospfb_adc_capture: RTL and testbench

- Single-clock OSPFB capture harness: ADC ramp model -> sample FIFO -> oversampled polyphase commutator (history buffer with per-frame phase rotation) -> capture RAM.
- Produces FFT_LEN-sample frames advancing DEC_FAC input samples per frame.
- Stores SAMP output samples and raises vip_full; results are read back through a RAM read port.

---
 rtl/ospfb_adc_capture.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ospfb_adc_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_adc_capture.sv
// ospfb_adc_capture: single-clock OSPFB capture harness.
// ADC ramp model -> FWFT sample FIFO -> polyphase commutator (history
// buffer with per-frame phase rotation) -> capture RAM with read port.
// Build option: define OSPFB_ROTATE_EN to advance the frame phase rotation
// by DEC_FAC every frame; left undefined, frames are emitted oldest-first.
module ospfb_adc_capture #(
    parameter int ADC_BITS          = 12,
    parameter int WIDTH             = 16,
    parameter int FFT_LEN           = 64,
    parameter int DEC_FAC           = 48,
    parameter int SRC_DIV           = 3,
    parameter int SAMP              = 256,
    parameter int FIFO_DEPTH        = 32,
    parameter int PROG_EMPTY_THRESH = 16,
    parameter int PROG_FULL_THRESH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [$clog2(SAMP)-1:0]       rd_addr,
    output logic [2*WIDTH-1:0]            rd_data,
    output logic                          vip_full,
    output logic                          ospfb_tready,
    output logic                          event_frame_started,
    output logic                          event_data_in_channel_halt,
    output logic                          fifo_overflow,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic                          prog_empty,
    output logic                          prog_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV_W   = (SRC_DIV > 1) ? $clog2(SRC_DIV) : 1;
    localparam int PTR_W   = $clog2(FFT_LEN);
    localparam int FPTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FPTR_W + 1;
    localparam int CAP_W   = $clog2(SAMP) + 1;
    localparam int NFRAMES = SAMP / FFT_LEN;
    localparam int FRM_W   = $clog2(NFRAMES) + 1;
    localparam int WORD_W  = 2 * WIDTH;

    typedef enum logic [2:0] {
        WAIT_FIFO,
        FILL,
        LOAD,
        EMIT,
        DONE
    } state_t;

    // ADC model signals
    logic [DIV_W-1:0]    div_cnt;
    logic                strobe;
    logic [ADC_BITS-1:0] ramp;
    logic [WIDTH-1:0]    adc_real;
    logic [WORD_W-1:0]   adc_word;

    // FIFO signals
    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FPTR_W-1:0]   fifo_wr_ptr;
    logic [FPTR_W-1:0]   fifo_rd_ptr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_wr;
    logic                fifo_rd;
    logic [WORD_W-1:0]   fifo_head;

    // Commutator signals
    state_t              state;
    state_t              state_nx;
    logic [PTR_W-1:0]    cnt;
    logic                cnt_inc;
    logic                cnt_clr;
    logic                pop;
    logic                emit;
    logic                frame_end;
    logic [FRM_W-1:0]    frame_cnt;
    logic [PTR_W-1:0]    w;
    logic [PTR_W-1:0]    r;
    logic [WORD_W-1:0]   hist [FFT_LEN];
    logic [PTR_W-1:0]    hist_raddr;

    // Emit pipeline and capture
    logic [WORD_W-1:0]   data_p1;
    logic                vld_p1;
    logic [CAP_W-1:0]    cap_addr;
    logic                cap_we;
    logic [WORD_W-1:0]   cap_ram [SAMP];

    // ---------------- ADC model ----------------
    assign strobe   = en && (div_cnt == DIV_W'(SRC_DIV - 1));
    assign adc_real = WIDTH'(ramp) << (WIDTH - ADC_BITS);
    assign adc_word = {{WIDTH{1'b0}}, adc_real};
    assign fifo_wr  = strobe && !fifo_full;

    // Strobe divider: counts enabled clocks, wraps on every strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
        end
    end

    // Ramp advances only on accepted samples; a strobe into a full FIFO latches overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp          <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (fifo_wr) begin
                ramp <= ramp + 1'b1;
            end
            if (strobe && fifo_full) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

    // ---------------- Sample FIFO (first-word-fall-through) ----------------
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_rd    = pop;
    assign fifo_head  = fifo_mem[fifo_rd_ptr];

    assign almost_full  = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign almost_empty = (fifo_count <= CNT_W'(1));
    assign prog_full    = (fifo_count >= CNT_W'(PROG_FULL_THRESH));
    assign prog_empty   = (fifo_count <= CNT_W'(PROG_EMPTY_THRESH));

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[fifo_wr_ptr] <= adc_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous read and write leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- Commutator FSM ----------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_FIFO;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-cycle controls
    always_comb begin
        state_nx                   = state;
        ospfb_tready               = 1'b0;
        pop                        = 1'b0;
        emit                       = 1'b0;
        cnt_clr                    = 1'b0;
        frame_end                  = 1'b0;
        event_frame_started        = 1'b0;
        event_data_in_channel_halt = 1'b0;
        case (state)
            WAIT_FIFO: begin
                if (!prog_empty) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                ospfb_tready = 1'b1;
                pop          = !fifo_empty;
                if (pop && (cnt == PTR_W'(FFT_LEN - DEC_FAC - 1))) begin
                    cnt_clr  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                ospfb_tready               = 1'b1;
                pop                        = !fifo_empty;
                event_data_in_channel_halt = fifo_empty;
                if (pop && (cnt == PTR_W'(DEC_FAC - 1))) begin
                    cnt_clr  = 1'b1;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                emit                = 1'b1;
                event_frame_started = (cnt == '0);
                if (cnt == PTR_W'(FFT_LEN - 1)) begin
                    frame_end = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nx  = (frame_cnt == FRM_W'(NFRAMES - 1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = WAIT_FIFO;
            end
        endcase
    end

    assign cnt_inc = pop || emit;

    // Phase counter: pops in FILL/LOAD, output index k in EMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame count, history write pointer and frame rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            w         <= '0;
            r         <= '0;
        end else begin
            if (pop) begin
                w <= w + 1'b1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
`ifdef OSPFB_ROTATE_EN
                r <= r + PTR_W'(DEC_FAC);
`else
                r <= '0;
`endif
            end
        end
    end

    // History buffer write; w always points at the oldest entry
    always_ff @(posedge clk) begin
        if (pop) begin
            hist[w] <= fifo_head;
        end
    end

    // ---- p0 -> p1: history read at (oldest + k + rotation) ----
    assign hist_raddr = w + cnt + r;

    // History read data register
    always_ff @(posedge clk) begin
        if (emit) begin
            data_p1 <= hist[hist_raddr];
        end
    end

    // Valid alongside the read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= emit;
        end
    end

    // ---- p1 -> capture RAM ----
    assign cap_we = vld_p1 && (cap_addr < CAP_W'(SAMP));

    // Capture RAM write
    always_ff @(posedge clk) begin
        if (cap_we) begin
            cap_ram[cap_addr[CAP_W-2:0]] <= data_p1;
        end
    end

    // Capture address (no wrap) and sticky completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
            vip_full <= 1'b0;
        end else if (cap_we) begin
            cap_addr <= cap_addr + 1'b1;
            if (cap_addr == CAP_W'(SAMP - 1)) begin
                vip_full <= 1'b1;
            end
        end
    end

    // Registered capture read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= cap_ram[rd_addr];
        end
    end

endmodule

// File: tb/tb_ospfb_adc_capture.sv
// Bench for ospfb_adc_capture: default instance (SRC_DIV=3) and a fast
// instance (SRC_DIV=1). Captured frames are compared against a reference
// built from the sliding-window definition of each OSPFB frame.
module tb_ospfb_adc_capture;

    localparam int ADC_BITS = 12;
    localparam int WIDTH    = 16;
    localparam int FFT_LEN  = 64;
    localparam int DEC_FAC  = 48;
    localparam int SAMP     = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_n, en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        vip_full, tready, ev_fs, ev_halt, ovf, a_empty, a_full, p_empty, p_full;
    logic [5:0]  fcount;

    // fast instance
    logic        rst_n_f, en_f;
    logic [7:0]  rd_addr_f;
    logic [31:0] rd_data_f;
    logic        vip_full_f, tready_f, ev_fs_f, ev_halt_f, ovf_f, a_empty_f, a_full_f, p_empty_f, p_full_f;
    logic [5:0]  fcount_f;

    ospfb_adc_capture dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
        .vip_full(vip_full), .ospfb_tready(tready), .event_frame_started(ev_fs),
        .event_data_in_channel_halt(ev_halt), .fifo_overflow(ovf),
        .almost_empty(a_empty), .almost_full(a_full), .prog_empty(p_empty),
        .prog_full(p_full), .fifo_count(fcount)
    );

    ospfb_adc_capture #(.SRC_DIV(1)) dut_f (
        .clk(clk), .rst_n(rst_n_f), .en(en_f), .rd_addr(rd_addr_f), .rd_data(rd_data_f),
        .vip_full(vip_full_f), .ospfb_tready(tready_f), .event_frame_started(ev_fs_f),
        .event_data_in_channel_halt(ev_halt_f), .fifo_overflow(ovf_f),
        .almost_empty(a_empty_f), .almost_full(a_full_f), .prog_empty(p_empty_f),
        .prog_full(p_full_f), .fifo_count(fcount_f)
    );

    int n_total = 0;
    int n_pass  = 0;

    // event monitors, sampled on the falling edge
    int frames   = 0;
    int frames_f = 0;
    int halts    = 0;
    bit af_seen_f = 1'b0;
    bit pf_seen_f = 1'b0;

    always @(negedge clk) begin
        if (ev_fs)    frames    <= frames + 1;
        if (ev_fs_f)  frames_f  <= frames_f + 1;
        if (ev_halt)  halts     <= halts + 1;
        if (a_full_f) af_seen_f <= 1'b1;
        if (p_full_f) pf_seen_f <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame f covers input samples f*D .. f*D+M-1. With rotation, word k is
    // the window sample whose history slot is (2*f*D + k) mod M.
    function automatic logic [31:0] exp_word(input int a);
        int f, k, s;
        f = a / FFT_LEN;
        k = a % FFT_LEN;
`ifdef OSPFB_ROTATE_EN
        s = f * DEC_FAC + ((f * DEC_FAC + k) % FFT_LEN);
`else
        s = f * DEC_FAC + k;
`endif
        return {16'h0000, 16'((s % (1 << ADC_BITS)) << (WIDTH - ADC_BITS))};
    endfunction

    task automatic read_word(input int a, input bit fast, output logic [31:0] v);
        @(negedge clk);
        if (fast) rd_addr_f = 8'(a);
        else      rd_addr   = 8'(a);
        @(negedge clk);
        v = fast ? rd_data_f : rd_data;
    endtask

    task automatic verify_capture(input string tag, input bit fast);
        int order[SAMP];
        int j, t;
        logic [31:0] v;
        for (int i = 0; i < SAMP; i++) order[i] = i;
        for (int i = SAMP - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < SAMP; i++) begin
            read_word(order[i], fast, v);
            check($sformatf("%s[%0d]", tag, order[i]), 64'(v), 64'(exp_word(order[i])));
        end
    endtask

    task automatic wait_vip(input bit fast, input bit rand_en, input int budget);
        int n;
        n = 0;
        while (((fast ? vip_full_f : vip_full) !== 1'b1) && n < budget) begin
            @(negedge clk);
            if (rand_en) en = ($urandom_range(0, 7) != 0);
            n++;
        end
        check(fast ? "vip_full_f_reached" : "vip_full_reached",
              64'(fast ? vip_full_f : vip_full), 64'(1));
    endtask

    initial begin
        logic [31:0] v;
        int base, n, dly;

        rst_n = 1'b0; rst_n_f = 1'b0; en = 1'b0; en_f = 1'b0;
        rd_addr = '0; rd_addr_f = '0;

        // reset state
        repeat (10) @(negedge clk);
        check("rst_vip_full",   64'(vip_full), 64'(0));
        check("rst_fifo_count", 64'(fcount),   64'(0));
        check("rst_prog_empty", 64'(p_empty),  64'(1));
        check("rst_alm_empty",  64'(a_empty),  64'(1));
        check("rst_tready",     64'(tready),   64'(0));
        check("rst_overflow",   64'(ovf),      64'(0));
        check("rst_prog_full",  64'(p_full),   64'(0));
        check("rst_alm_full",   64'(a_full),   64'(0));
        check("rst_rd_data",    64'(rd_data),  64'(0));
        check("rst_tready_f",   64'(tready_f), 64'(0));

        // released with en=0: stays waiting
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_tready",     64'(tready), 64'(0));
        check("idle_fifo_count", 64'(fcount), 64'(0));
        check("idle_frames",     64'(frames), 64'(0));

        // default run with randomly gapped enable
        wait_vip(1'b0, 1'b1, 20000);
        check("frames_at_full", 64'(frames), 64'(4));
        check("halt_seen", 64'(halts > 0), 64'(1));
        read_word(5, 1'b0, v);
        check("f0_w5", 64'(v), 64'(32'd5 * 16));
`ifdef OSPFB_ROTATE_EN
        read_word(64, 1'b0, v);
        check("f1_w0_rot", 64'(v), 64'(32'd96 * 16));
        read_word(80, 1'b0, v);
        check("f1_w16_rot", 64'(v), 64'(32'd48 * 16));
`else
        read_word(64, 1'b0, v);
        check("f1_w0", 64'(v), 64'(32'd48 * 16));
        read_word(80, 1'b0, v);
        check("f1_w16", 64'(v), 64'(32'd64 * 16));
`endif

        // completion hold
        en = 1'b1;
        @(negedge clk);
        rd_addr = 8'd255;
        repeat (1000) @(negedge clk);
        check("hold_frames",    64'(frames),  64'(4));
        check("hold_vip_full",  64'(vip_full), 64'(1));
        check("hold_tready",    64'(tready),  64'(0));
        check("hold_overflow",  64'(ovf),     64'(1));
        check("hold_fifo_cnt",  64'(fcount),  64'(32));
        check("hold_alm_full",  64'(a_full),  64'(1));
        check("hold_prog_full", 64'(p_full),  64'(1));
        check("hold_rd255",     64'(rd_data), 64'(exp_word(255)));
        verify_capture("cap", 1'b0);

        // fast source: overflow during the first EMIT
        rst_n_f = 1'b1; en_f = 1'b1;
        n = 0;
        while (frames_f < 1 && n < 3000) begin @(negedge clk); n++; end
        check("fast_first_frame", 64'(frames_f >= 1), 64'(1));
        repeat (FFT_LEN - 1) @(negedge clk);
        check("fast_ovf_in_emit", 64'(ovf_f), 64'(1));
        wait_vip(1'b1, 1'b0, 20000);
        check("fast_af_seen", 64'(af_seen_f), 64'(1));
        check("fast_pf_seen", 64'(pf_seen_f), 64'(1));
        verify_capture("cap_f", 1'b1);

        // reset during frame 2 EMIT, then a clean restart
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        base = frames;
        n = 0;
        while ((frames - base) < 3 && n < 5000) begin @(negedge clk); n++; end
        check("mid_frame2_reached", 64'((frames - base) >= 3), 64'(1));
        dly = int'($urandom_range(1, 60));
        repeat (dly) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vip_full", 64'(vip_full), 64'(0));
        check("mid_rst_fcount",   64'(fcount),   64'(0));
        check("mid_rst_ovf",      64'(ovf),      64'(0));
        check("mid_rst_tready",   64'(tready),   64'(0));
        check("mid_rst_pempty",   64'(p_empty),  64'(1));
        check("mid_rst_ev_fs",    64'(ev_fs),    64'(0));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        base = frames;
        wait_vip(1'b0, 1'b0, 20000);
        check("restart_frames", 64'(frames - base), 64'(4));
        verify_capture("cap_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
